// File: rtl/move_gen_ctrl_if.sv
// Move-stream and FIFO-read bundle between the sequencer and the square array.
// The master side is the sequencer: it selects and pops square FIFOs and
// drives the valid/ready move stream towards the search logic.
interface move_gen_ctrl_if;
  logic [47:0] mv_data;
  logic        mv_valid;
  logic        mv_ready;
  logic [5:0]  rd_sel;
  logic        rd_en;
  logic [47:0] fifo_data;
  logic        fifo_empty;

  modport master (
    output mv_data, mv_valid, rd_sel, rd_en,
    input  mv_ready, fifo_data, fifo_empty
  );

  modport slave (
    input  mv_data, mv_valid, rd_sel, rd_en,
    output mv_ready, fifo_data, fifo_empty
  );
endinterface

// File: rtl/move_gen_ctrl.sv
// Sequencer for the 8x8 array of square units: latches a board, pulses the
// squares' new-board reset, masks their done flags while pieces propagate,
// waits for all 64 done flags (or aborts on timeout), then drains every
// square's move FIFO in square order onto a single valid/ready stream.
module move_gen_ctrl #(
  parameter int HOLD_CYC = 16,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [255:0]     board_in,
  output logic [255:0]     cpiece_bus,
  output logic             sq_reset,
  output logic             sq_hold,
  input  logic [63:0]      done_vec,
  output logic             busy,
  output logic             scan_done,
  output logic             err,
  output logic [CNT_W-1:0] move_count,
  move_gen_ctrl_if.master  mif
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_SETTLE,
    S_WAIT,
    S_CHECK,
    S_CAPT,
    S_SEND,
    S_FIN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TO_W-1:0]   wait_cnt;
  logic              all_done;
  logic              timed_out;

  // Done flags are ignored in the first WAIT cycle so stale flags from the
  // previous board cannot slip through right after hold drops.
  assign all_done  = (&done_vec) && (wait_cnt != '0);
  assign timed_out = (wait_cnt == TO_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a simultaneous done and timeout favours the drain.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_PULSE;
      S_PULSE:  state_nxt = S_SETTLE;
      S_SETTLE: if (hold_cnt == '0) state_nxt = S_WAIT;
      S_WAIT: begin
        if (all_done) begin
          state_nxt = S_CHECK;
        end else if (timed_out) begin
          state_nxt = S_FIN;
        end
      end
      S_CHECK: begin
        if (!mif.fifo_empty) begin
          state_nxt = S_CAPT;
        end else if (mif.rd_sel == 6'd63) begin
          state_nxt = S_FIN;
        end
      end
      S_CAPT:   state_nxt = S_SEND;
      S_SEND:   if (mif.mv_ready) state_nxt = S_CHECK;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded purely from state; rd_en only fires from CHECK, which
  // keeps it disjoint from both sq_reset and a pending mv_valid.
  always_comb begin
    sq_reset  = 1'b0;
    sq_hold   = 1'b0;
    mif.rd_en = 1'b0;
    scan_done = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_PULSE: begin
        sq_reset = 1'b1;
        sq_hold  = 1'b1;
      end
      S_SETTLE: sq_hold   = 1'b1;
      S_CHECK:  mif.rd_en = ~mif.fifo_empty;
      S_FIN:    scan_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: board latch, counters, FIFO index and move word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpiece_bus   <= '0;
      err          <= 1'b0;
      move_count   <= '0;
      mif.mv_data  <= '0;
      mif.mv_valid <= 1'b0;
      mif.rd_sel   <= '0;
      hold_cnt     <= '0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cpiece_bus <= board_in;
            err        <= 1'b0;
            move_count <= '0;
          end
        end
        S_PULSE: begin
          hold_cnt <= HOLD_W'(HOLD_CYC - 1);
        end
        S_SETTLE: begin
          wait_cnt <= '0;
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + TO_W'(1);
          if (state_nxt == S_CHECK) begin
            mif.rd_sel <= '0;
          end else if (state_nxt == S_FIN) begin
            err <= 1'b1;
          end
        end
        S_CHECK: begin
          if (mif.fifo_empty && (mif.rd_sel != 6'd63)) begin
            mif.rd_sel <= mif.rd_sel + 6'd1;
          end
        end
        S_CAPT: begin
          mif.mv_data  <= mif.fifo_data;
          mif.mv_valid <= 1'b1;
        end
        S_SEND: begin
          if (mif.mv_ready) begin
            mif.mv_valid <= 1'b0;
            if (move_count != '1) begin
              move_count <= move_count + CNT_W'(1);
            end
          end
        end
        S_FIN: begin
          mif.rd_sel <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/move_gen_ctrl.md
Name: move_gen_ctrl

Overview:
- Sequencer for the 8x8 array of square units.
- Latches a board and pushes it to every square's cpiece input, then pulses the squares' new-board reset.
- Masks done with hold during propagation, then waits for all 64 done flags (or a timeout).
- Drains each square's move FIFO in square order (0..63) onto one valid/ready move stream for the search logic.

Parameters:
- HOLD_CYC, 16, cycles hold stays high after the sq_reset pulse; must cover the longest slider propagation.
- TIMEOUT, 1024, max WAIT_DONE cycles before abort with err.
- CNT_W, 16, width of move_count.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  one-cycle request to evaluate board_in; ignored unless busy=0.
- board_in  in  256  64 x 4-bit pieces, square n = bits [4n+3:4n], n = 8*ypos + xpos; bit 3 is colour (0 = white).
- cpiece_bus  out  256  registered board to the squares, same packing.
- sq_reset  out  1  one-cycle new-board pulse to all squares.
- sq_hold  out  1  hold to all squares (done masking).
- done_vec  in  64  done flag of each square.
- rd_sel  out  6  index of the square whose FIFO is being read.
- rd_en  out  1  one-cycle pop of the selected FIFO.
- fifo_data  in  48  selected FIFO head; valid exactly 1 cycle after rd_en.
- fifo_empty  in  1  empty flag of the selected FIFO, combinational on rd_sel.
- mv_data  out  48  move word (8 packed 6-bit source positions).
- mv_valid  out  1  mv_data valid.
- mv_ready  in  1  downstream accept.
- busy  out  1  high in every state except IDLE.
- scan_done  out  1  one-cycle pulse at end of a scan.
- err  out  1  high if the last scan timed out; cleared at the next accepted start.
- move_count  out  CNT_W  words delivered this scan; saturates at all-ones.

Behaviour:
- Reset values: all outputs 0; cpiece_bus 0 (all EMPTY); state IDLE; counters 0.
- IDLE: start=1 latches board_in into cpiece_bus, clears err and move_count, goes to PULSE.
- PULSE (1 cycle): sq_reset=1, sq_hold=1. Go to SETTLE with the hold counter = HOLD_CYC-1.
- SETTLE: sq_hold=1; counter decrements; at 0 go to WAIT.
- WAIT: sq_hold=0; timeout counter increments from 0.
  - done_vec all ones, sampled 1 cycle after entry or later: go to DRAIN with rd_sel=0.
  - Counter reaches TIMEOUT-1 first: err=1, go to FIN; FIFOs are not drained.
- DRAIN is split into CHECK, CAPT and SEND:
  - CHECK, fifo_empty=1: if rd_sel=63 go to FIN, else rd_sel+1 and stay in CHECK.
  - CHECK, fifo_empty=0: rd_en=1 for that cycle, go to CAPT.
  - CAPT: mv_data <= fifo_data, mv_valid <= 1, go to SEND.
  - SEND: hold mv_data/mv_valid stable until mv_ready=1. On the handshake cycle: mv_valid <= 0, move_count+1 (saturating), back to CHECK with the same rd_sel.
  - Minimum 3 cycles per word. mv_ready is ignored while mv_valid=0.
- FIN (1 cycle): scan_done=1, rd_sel <= 0, go to IDLE.
- rd_sel wrap: never increments past 63; FIN is the only exit from the drain loop.
- start while busy=1: ignored, no queuing. cpiece_bus stays constant for the whole scan.
- Async reset mid-scan: immediate return to IDLE, outputs to reset values; an in-flight mv_valid is dropped.
- sq_reset and rd_en are never high in the same cycle. rd_en is never high while mv_valid=1.

Test Plan:
- Reset then idle: all outputs 0 after reset release; start=0 for 20 cycles -> busy stays 0.
- Normal scan, HOLD_CYC=16, all FIFOs empty: start; done_vec all ones from cycle 5 -> sq_reset high exactly cycle 1, sq_hold high cycles 1..17, 64 CHECK cycles, scan_done pulse, move_count=0.
- Drain with backpressure: FIFO 0 holds 2 words (0x0123456789AB, 0xFEDCBA987654), FIFO 63 holds 1 word, mv_ready toggling 1-in-3 -> 3 words out in that order, each stable while mv_valid=1 and mv_ready=0; move_count=3.
- Timeout, TIMEOUT=1024: done_vec bit 17 stuck at 0 -> err=1 and scan_done exactly 1024 cycles after WAIT entry; no rd_en ever asserted.
- Start while busy, plus async reset: second start during SETTLE -> no effect, cpiece_bus unchanged; reset low during SEND -> mv_valid=0 and busy=0 immediately, next start runs a clean scan.
- Hold masking: done_vec all ones throughout (stale) -> no transition to DRAIN before the first WAIT cycle; first rd_sel activity occurs at least HOLD_CYC+2 cycles after start.
